multi_alarm_clk: RTL
====================

MULTI_ALARM_CLK -- requirements
Module: multi_alarm_clk

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm registers (1..16).
REQ-002 Parameter CLKS_PER_MIN, default 15360, clk cycles per minute tick (256 Hz x 60).
REQ-003 Parameter SNOOZE_MIN, default 5, minutes between snooze and re-ring (1..255).
REQ-004 Parameter RING_MAX_MIN, default 3, minutes of continuous ringing before auto-stop (1..255).
REQ-005 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port fast_watch  in  1  when high, minute tick every clk cycle.
REQ-008 Port load_time  in  1  single-cycle strobe: write new_time into current time.
REQ-009 Port load_alarm  in  1  single-cycle strobe: write new_time and alarm_en_wr into alarm[alarm_sel].
REQ-010 Port alarm_sel  in  $clog2(NUM_ALARMS) (min 1)  alarm index for load_alarm.
REQ-011 Port alarm_en_wr  in  1  enable bit written with load_alarm.
REQ-012 Port new_time  in  16  BCD {ms_hr, ls_hr, ms_min, ls_min}, 4 bits each.
REQ-013 Port snooze  in  1  single-cycle strobe.
REQ-014 Port stop  in  1  single-cycle strobe.
REQ-015 Port current_time  out  16  BCD current time, same packing as new_time.
REQ-016 Port sound_alarm  out  1  high exactly while FSM is RINGING.
REQ-017 Port active_alarm  out  $clog2(NUM_ALARMS)  index of alarm that triggered the current ring/snooze cycle.
REQ-018 Port alarm_en  out  NUM_ALARMS  per-alarm enable status.

Function
REQ-019 Prescaler counts 0..CLKS_PER_MIN-1; minute tick asserted in the cycle it equals CLKS_PER_MIN-1, then wraps to 0; fast_watch forces tick every cycle.
REQ-020 On tick, current_time increments in BCD: ls_min 9->0 carries to ms_min; ms_min 5->0 carries to hour; 09->10, 19->20, 23:59->00:00.
REQ-021 new_time is valid only if every digit <= 9, hour <= 23, ms_min <= 5; an invalid load_time or load_alarm is ignored entirely.
REQ-022 Valid load_time updates current_time on the next edge and clears the prescaler; load_time wins over a coincident tick.
REQ-023 Alarm match is evaluated only on tick, against the incremented time; never on load_time.
REQ-024 FSM states IDLE, RINGING, SNOOZED; sound_alarm decoded from state with zero latency.
REQ-025 IDLE -> RINGING on the edge where current_time becomes T, if any enabled alarm equals T; lowest matching index latched into active_alarm; ring-minute counter cleared.
REQ-026 RINGING: stop -> IDLE; else snooze -> SNOOZED with snooze counter loaded to SNOOZE_MIN; else each tick increments ring counter, reaching RING_MAX_MIN -> IDLE.
REQ-027 SNOOZED: stop -> IDLE; else each tick decrements snooze counter, reaching 0 -> RINGING with ring counter cleared; snooze ignored.
REQ-028 stop has priority over snooze; both have priority over a coincident tick.
REQ-029 New matches while RINGING or SNOOZED are ignored; writing alarm[active_alarm], including clearing its enable, does not alter the current ring/snooze cycle.
REQ-030 load_alarm updates the selected alarm on the next edge; alarm_sel >= NUM_ALARMS is ignored.

Reset
REQ-031 reset: current_time = 00:00 (16'h0000), prescaler 0, all alarms 00:00 and disabled, alarm_en all 0, FSM IDLE, sound_alarm 0, active_alarm 0, counters 0.
REQ-032 reset overrides every other input in the same cycle, including mid-ring and mid-snooze.

Structure
REQ-033 Package aclk_pkg holds bcd_time_t (packed struct, four 4-bit digits), ring_state_t enum, bcd_valid() and bcd_inc_minute() functions.
REQ-034 Prescaler is the sub-module aclk_minute_prescaler (clk, reset, fast_watch, clear, tick), parametrised by CLKS_PER_MIN.

Verification
REQ-035 Time 23:59 loaded, fast_watch=1, one cycle -> current_time 16'h0000; 09:59 -> 16'h1000.
REQ-036 Alarm 2 = 07:30 enabled, load 07:29, one tick -> sound_alarm=1, active_alarm=2 on same edge; alarms 1 and 2 both 07:30 -> active_alarm=1.
REQ-037 Ringing, snooze pulse -> sound_alarm=0; after exactly SNOOZE_MIN=5 ticks -> sound_alarm=1; stop -> IDLE, no further ring.
REQ-038 Ringing with no input -> sound_alarm drops at RING_MAX_MIN=3rd tick; stop and snooze same cycle -> IDLE.
REQ-039 load_time 24:00, 12:60 and 1A:00 -> current_time unchanged; load_alarm with same values -> alarm_en unchanged.
REQ-040 reset asserted during SNOOZED -> all outputs at reset values next edge; subsequent snooze timeout produces no ring.

Source files
------------

// File: rtl/aclk_pkg.sv
// Shared types and BCD helpers for the multi-alarm clock: time packing,
// ring FSM states, time validation and the minute increment.
package aclk_pkg;

   typedef struct packed {
      logic [3:0] ms_hr;
      logic [3:0] ls_hr;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } bcd_time_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RINGING,
      ST_SNOOZED
   } ring_state_t;

   function automatic logic bcd_valid(input bcd_time_t t);
      logic ok;
      ok = (t.ls_min <= 4'd9) && (t.ms_min <= 4'd5) &&
           (t.ls_hr <= 4'd9) && (t.ms_hr <= 4'd2);
      if ((t.ms_hr == 4'd2) && (t.ls_hr > 4'd3)) ok = 1'b0;
      return ok;
   endfunction

   // Minute carries into the hour, and 23:59 rolls over to 00:00.
   function automatic bcd_time_t bcd_inc_minute(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.ls_min != 4'd9) begin
         r.ls_min = t.ls_min + 4'd1;
      end else begin
         r.ls_min = 4'd0;
         if (t.ms_min != 4'd5) begin
            r.ms_min = t.ms_min + 4'd1;
         end else begin
            r.ms_min = 4'd0;
            if ((t.ms_hr == 4'd2) && (t.ls_hr == 4'd3)) begin
               r.ms_hr = 4'd0;
               r.ls_hr = 4'd0;
            end else if (t.ls_hr == 4'd9) begin
               r.ls_hr = 4'd0;
               r.ms_hr = t.ms_hr + 4'd1;
            end else begin
               r.ls_hr = t.ls_hr + 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/aclk_minute_prescaler.sv
// Divides clk down to a one-cycle minute tick; fast_watch forces a tick
// every cycle and clear restarts the count from zero.
module aclk_minute_prescaler #(
   parameter int CLKS_PER_MIN = 15360
) (
   input  logic clk,
   input  logic reset,
   input  logic fast_watch,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_MIN > 1) ? $clog2(CLKS_PER_MIN) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MIN - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = fast_watch | (cnt_q == LAST);

endmodule

// File: rtl/multi_alarm_clk.sv
// BCD time-of-day clock with NUM_ALARMS alarm registers and a
// ring / snooze / auto-stop state machine.
module multi_alarm_clk
   import aclk_pkg::*;
#(
   parameter int NUM_ALARMS   = 4,
   parameter int CLKS_PER_MIN = 15360,
   parameter int SNOOZE_MIN   = 5,
   parameter int RING_MAX_MIN = 3,
   localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fast_watch,
   input  logic                  load_time,
   input  logic                  load_alarm,
   input  logic [AW-1:0]         alarm_sel,
   input  logic                  alarm_en_wr,
   input  logic [15:0]           new_time,
   input  logic                  snooze,
   input  logic                  stop,
   output logic [15:0]           current_time,
   output logic                  sound_alarm,
   output logic [AW-1:0]         active_alarm,
   output logic [NUM_ALARMS-1:0] alarm_en
);

   localparam logic [AW:0] NUM_AL     = (AW + 1)'(NUM_ALARMS);
   localparam logic [7:0]  SNOOZE_LD  = 8'(SNOOZE_MIN);
   localparam logic [7:0]  RING_LAST  = 8'(RING_MAX_MIN - 1);

   bcd_time_t             new_bcd, next_min;
   bcd_time_t             time_q, time_d;
   bcd_time_t             alarm_time_q [NUM_ALARMS];
   bcd_time_t             alarm_time_d [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] alarm_en_q, alarm_en_d;
   logic                  tick, load_time_ok, load_alarm_ok, minute_step;
   logic                  match_any;
   logic [AW-1:0]         match_idx;

   ring_state_t           state_q;
   logic [7:0]            ring_cnt_q, snooze_cnt_q;
   logic [AW-1:0]         active_q;
   logic                  sound_q;

   aclk_minute_prescaler #(
      .CLKS_PER_MIN (CLKS_PER_MIN)
   ) u_prescaler (
      .clk        (clk),
      .reset      (reset),
      .fast_watch (fast_watch),
      .clear      (load_time_ok),
      .tick       (tick)
   );

   assign new_bcd       = bcd_time_t'(new_time);
   assign load_time_ok  = load_time & bcd_valid(new_bcd);
   assign load_alarm_ok = load_alarm & bcd_valid(new_bcd) & ({1'b0, alarm_sel} < NUM_AL);
   assign minute_step   = tick & ~load_time_ok;
   assign next_min      = bcd_inc_minute(time_q);

   always_comb begin
      time_d = time_q;
      if (load_time_ok)     time_d = new_bcd;
      else if (minute_step) time_d = next_min;
   end

   always_comb begin
      alarm_en_d = alarm_en_q;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         alarm_time_d[i] = alarm_time_q[i];
         if (load_alarm_ok && (AW'(i) == alarm_sel)) begin
            alarm_time_d[i] = new_bcd;
            alarm_en_d[i]   = alarm_en_wr;
         end
      end
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (alarm_en_q[i] && (alarm_time_q[i] == next_min)) begin
            match_any = 1'b1;
            match_idx = AW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         time_q     <= '0;
         alarm_en_q <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) alarm_time_q[i] <= '0;
      end else begin
         time_q     <= time_d;
         alarm_en_q <= alarm_en_d;
         for (int i = 0; i < NUM_ALARMS; i++) alarm_time_q[i] <= alarm_time_d[i];
      end
   end

   // sound_q is updated together with the state so it tracks RINGING exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ring_cnt_q   <= '0;
         snooze_cnt_q <= '0;
         active_q     <= '0;
         sound_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (minute_step && match_any) begin
                  state_q    <= ST_RINGING;
                  active_q   <= match_idx;
                  ring_cnt_q <= '0;
                  sound_q    <= 1'b1;
               end
            end
            ST_RINGING: begin
               if (stop) begin
                  state_q <= ST_IDLE;
                  sound_q <= 1'b0;
               end else if (snooze) begin
                  state_q      <= ST_SNOOZED;
                  snooze_cnt_q <= SNOOZE_LD;
                  sound_q      <= 1'b0;
               end else if (minute_step) begin
                  if (ring_cnt_q == RING_LAST) begin
                     state_q <= ST_IDLE;
                     sound_q <= 1'b0;
                  end else begin
                     ring_cnt_q <= ring_cnt_q + 8'd1;
                  end
               end
            end
            ST_SNOOZED: begin
               if (stop) begin
                  state_q <= ST_IDLE;
               end else if (minute_step) begin
                  if (snooze_cnt_q <= 8'd1) begin
                     state_q      <= ST_RINGING;
                     ring_cnt_q   <= '0;
                     snooze_cnt_q <= '0;
                     sound_q      <= 1'b1;
                  end else begin
                     snooze_cnt_q <= snooze_cnt_q - 8'd1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               sound_q <= 1'b0;
            end
         endcase
      end
   end

   assign current_time = time_q;
   assign sound_alarm  = sound_q;
   assign active_alarm = active_q;
   assign alarm_en     = alarm_en_q;

endmodule
